// File: rtl/video_package.sv
// Shared display-memory types for the text-mode video path, plus the
// write-queue FSM state encoding.
package video_package;

  localparam int DISP_ADDR_W = 12;

  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
  typedef logic [3:0]             color_t;

  typedef struct packed {
    color_t     back;
    color_t     fore;
    logic [7:0] chr;
  } disp_data_t;

  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_DRAIN = 2'd1,
    Q_FLUSH = 2'd2
  } wr_queue_st;

endpackage

// File: rtl/disp_wr_fifo.sv
// Storage, pointers and level for the display write queue. pop_i is only
// honoured when the queue is non-empty; a push at full needs a same-cycle pop.
module disp_wr_fifo
  import video_package::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          push_i,
  input  disp_addr_t    push_addr_i,
  input  disp_data_t    push_data_i,
  input  logic          pop_i,
  output disp_addr_t    head_addr_o,
  output disp_data_t    head_data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  disp_addr_t     addr_mem [DEPTH];
  disp_data_t     data_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic           push_ok;
  logic           pop_ok;

  assign pop_ok  = pop_i && (level_q != '0);
  assign push_ok = push_i && ((level_q != FULL_LVL) || pop_ok);

  // Array is not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr_i;
      data_mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign head_addr_o = addr_mem[rd_ptr];
  assign head_data_o = data_mem[rd_ptr];
  assign level_o     = level_q;
  assign full_o      = (level_q == FULL_LVL);

endmodule

// File: rtl/disp_wr_queue.sv
// Buffers CPU writes to display memory and drains them during vertical blank
// (or on an explicit flush) whenever scanout is not using the RAM port.
module disp_wr_queue
  import video_package::*;
#(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  disp_addr_t    wr_addr_i,
  input  disp_data_t    wr_data_i,
  input  logic          vblank_i,
  input  logic          flush_i,
  input  logic          ram_busy_i,
  input  logic          clear_ovf_i,
  output logic          ram_wr_en_o,
  output disp_addr_t    ram_wr_addr_o,
  output disp_data_t    ram_wr_data_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o,
  output wr_queue_st    state_o
);

  wr_queue_st state_q;
  disp_addr_t head_addr;
  disp_data_t head_data;
  logic       pop;
  logic       drop;

  // A push into an empty queue leaves level at 0 this cycle, so it cannot be
  // popped until the next one.
  assign pop  = (state_q != Q_IDLE) && (level_o != '0) && !ram_busy_i;
  assign drop = wr_en_i && full_o && !pop;

  disp_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .push_i      (wr_en_i),
    .push_addr_i (wr_addr_i),
    .push_data_i (wr_data_i),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .level_o     (level_o),
    .full_o      (full_o)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Q_IDLE;
    end else begin
      case (state_q)
        Q_IDLE: begin
          if (flush_i)                        state_q <= Q_FLUSH;
          else if (vblank_i && level_o != '0) state_q <= Q_DRAIN;
        end
        Q_DRAIN: begin
          if (flush_i)                           state_q <= Q_FLUSH;
          else if (!vblank_i || level_o == '0)   state_q <= Q_IDLE;
        end
        Q_FLUSH: begin
          if (level_o == '0) state_q <= Q_IDLE;
        end
        default: state_q <= Q_IDLE;
      endcase
    end
  end

  // Address/data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
    end else begin
      ram_wr_en_o <= pop;
      if (pop) begin
        ram_wr_addr_o <= head_addr;
        ram_wr_data_o <= head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)          overflow_o <= 1'b0;
    else if (clear_ovf_i) overflow_o <= 1'b0;
    else if (drop)        overflow_o <= 1'b1;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_disp_wr_queue.sv
// Bench for disp_wr_queue: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_disp_wr_queue;
  import video_package::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_ni;
  logic          wr_en_i;
  disp_addr_t    wr_addr_i;
  disp_data_t    wr_data_i;
  logic          vblank_i;
  logic          flush_i;
  logic          ram_busy_i;
  logic          clear_ovf_i;
  logic          ram_wr_en_o;
  disp_addr_t    ram_wr_addr_o;
  disp_data_t    ram_wr_data_o;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  wr_queue_st    state_o;

  disp_wr_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .vblank_i      (vblank_i),
    .flush_i       (flush_i),
    .ram_busy_i    (ram_busy_i),
    .clear_ovf_i   (clear_ovf_i),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .full_o        (full_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .state_o       (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    disp_addr_t addr;
    disp_data_t data;
  } entry_t;

  entry_t     exp_q[$];
  wr_queue_st m_state;
  logic       m_ovf;
  logic       m_en;
  disp_addr_t m_addr;
  disp_data_t m_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = Q_IDLE;
    m_ovf   = 1'b0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic idle_inputs();
    wr_en_i     = 1'b0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    vblank_i    = 1'b0;
    flush_i     = 1'b0;
    ram_busy_i  = 1'b0;
    clear_ovf_i = 1'b0;
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic step();
    int     lvl;
    logic   pop;
    logic   push;
    entry_t e;
    lvl  = exp_q.size();
    pop  = (m_state != Q_IDLE) && (lvl > 0) && !ram_busy_i;
    push = wr_en_i && ((lvl < DEPTH) || pop);
    case (m_state)
      Q_IDLE:  if (flush_i) m_state = Q_FLUSH;
               else if (vblank_i && lvl > 0) m_state = Q_DRAIN;
      Q_DRAIN: if (flush_i) m_state = Q_FLUSH;
               else if (!vblank_i || lvl == 0) m_state = Q_IDLE;
      default: if (lvl == 0) m_state = Q_IDLE;
    endcase
    if (clear_ovf_i) m_ovf = 1'b0;
    else if (wr_en_i && !push) m_ovf = 1'b1;
    m_en = pop;
    if (pop) begin
      e = exp_q.pop_front();
      m_addr = e.addr;
      m_data = e.data;
    end
    if (push) exp_q.push_back({wr_addr_i, wr_data_i});
    @(posedge clk);
    #1;
    if (ram_wr_en_o === 1'b1) n_writes++;
    check("ram_wr_en", 32'(ram_wr_en_o), 32'(m_en));
    check("ram_wr_addr", 32'(ram_wr_addr_o), 32'(m_addr));
    check("ram_wr_data", 32'(ram_wr_data_o), 32'(m_data));
    check("level", 32'(level_o), 32'(exp_q.size()));
    check("full", 32'(full_o), 32'(exp_q.size() == DEPTH));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("state", 32'(state_o), 32'(m_state));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #2;
    check("rst_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
    check("rst_ram_wr_addr", 32'(ram_wr_addr_o), 32'd0);
    check("rst_ram_wr_data", 32'(ram_wr_data_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(Q_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = disp_addr_t'(base + i);
      wr_data_i = disp_data_t'($urandom_range(0, 65535));
      step();
    end
    wr_en_i = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       wr_en;
    disp_addr_t addr;
    logic [15:0] data;
    logic       vblank;
    logic       exp_en;
    disp_addr_t exp_addr;
    logic [15:0] exp_data;
    int         exp_level;
    wr_queue_st exp_state;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 12'd0, 16'h0148, 1'b0, 1'b0, 12'd0, 16'h0000, 1, Q_IDLE};
    vecs[1] = '{1'b1, 12'd1, 16'h0265, 1'b0, 1'b0, 12'd0, 16'h0000, 2, Q_IDLE};
    vecs[2] = '{1'b1, 12'd2, 16'h036C, 1'b0, 1'b0, 12'd0, 16'h0000, 3, Q_IDLE};
    vecs[3] = '{1'b0, 12'd0, 16'h0000, 1'b1, 1'b0, 12'd0, 16'h0000, 3, Q_DRAIN};
    vecs[4] = '{1'b0, 12'd0, 16'h0000, 1'b1, 1'b1, 12'd0, 16'h0148, 2, Q_DRAIN};
    vecs[5] = '{1'b0, 12'd0, 16'h0000, 1'b1, 1'b1, 12'd1, 16'h0265, 1, Q_DRAIN};
    vecs[6] = '{1'b0, 12'd0, 16'h0000, 1'b1, 1'b1, 12'd2, 16'h036C, 0, Q_DRAIN};
    vecs[7] = '{1'b0, 12'd0, 16'h0000, 1'b1, 1'b0, 12'd2, 16'h036C, 0, Q_IDLE};
    vecs[8] = '{1'b0, 12'd0, 16'h0000, 1'b0, 1'b0, 12'd2, 16'h036C, 0, Q_IDLE};

    idle_inputs();
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Basic in-order drain during vblank.
    for (int i = 0; i < 9; i++) begin
      wr_en_i   = vecs[i].wr_en;
      wr_addr_i = vecs[i].addr;
      wr_data_i = vecs[i].data;
      vblank_i  = vecs[i].vblank;
      step();
      check($sformatf("vec%0d_en", i), 32'(ram_wr_en_o), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_addr", i), 32'(ram_wr_addr_o), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i), 32'(ram_wr_data_o), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
    end

    // Overflow: nine pushes into an eight-deep queue.
    do_reset();
    push_n(8, 100);
    check("full_after_8", 32'(full_o), 32'd1);
    check("ovf_after_8", 32'(overflow_o), 32'd0);
    push_n(1, 200);
    check("level_after_9", 32'(level_o), 32'd8);
    check("ovf_after_9", 32'(overflow_o), 32'd1);
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Push and pop in the same cycle while full.
    vblank_i = 1'b1;
    step();
    check("full_enter_drain", 32'(state_o), 32'(Q_DRAIN));
    wr_en_i   = 1'b1;
    wr_addr_i = 12'd300;
    wr_data_i = 16'hABCD;
    step();
    wr_en_i = 1'b0;
    check("full_pushpop_level", 32'(level_o), 32'd8);
    check("full_pushpop_ovf", 32'(overflow_o), 32'd0);
    check("full_pushpop_addr", 32'(ram_wr_addr_o), 32'd100);
    for (int i = 0; i < 12 && level_o != 0; i++) step();
    step();
    check("full_drained_addr", 32'(ram_wr_addr_o), 32'd300);
    check("full_drained_state", 32'(state_o), 32'(Q_IDLE));
    vblank_i = 1'b0;

    // Drain with scanout busy on alternate cycles.
    do_reset();
    push_n(4, 400);
    vblank_i = 1'b1;
    n_writes = 0;
    for (int i = 0; i < 12; i++) begin
      ram_busy_i = i[0];
      step();
    end
    ram_busy_i = 1'b0;
    vblank_i   = 1'b0;
    check("busy_write_count", 32'(n_writes), 32'd4);
    check("busy_level", 32'(level_o), 32'd0);

    // vblank ends early, then a flush empties the rest.
    do_reset();
    push_n(4, 500);
    vblank_i = 1'b1;
    step();
    step();
    vblank_i = 1'b0;
    step();
    check("vbl_fall_state", 32'(state_o), 32'(Q_IDLE));
    check("vbl_fall_level", 32'(level_o), 32'd2);
    check("vbl_fall_addr", 32'(ram_wr_addr_o), 32'd501);
    n_writes = 0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_state", 32'(state_o), 32'(Q_FLUSH));
    for (int i = 0; i < 4; i++) step();
    check("flush_writes", 32'(n_writes), 32'd2);
    check("flush_last_addr", 32'(ram_wr_addr_o), 32'd503);
    check("flush_done_state", 32'(state_o), 32'(Q_IDLE));

    // Reset in the middle of a drain.
    do_reset();
    push_n(7, 600);
    vblank_i = 1'b1;
    step();
    step();
    step();
    check("pre_rst_level", 32'(level_o), 32'd5);
    check("pre_rst_en", 32'(ram_wr_en_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_en", 32'(ram_wr_en_o), 32'd0);
    check("mid_rst_level", 32'(level_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    n_writes = 0;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_level", 32'(level_o), 32'd0);
    check("post_rst_writes", 32'(n_writes), 32'd0);
    vblank_i = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      wr_en_i     = ($urandom_range(0, 99) < 55);
      wr_addr_i   = disp_addr_t'($urandom_range(0, 4095));
      wr_data_i   = disp_data_t'($urandom_range(0, 65535));
      if ($urandom_range(0, 99) < 10) vblank_i = ~vblank_i;
      flush_i     = ($urandom_range(0, 99) < 3);
      ram_busy_i  = ($urandom_range(0, 99) < 30);
      clear_ovf_i = ($urandom_range(0, 99) < 5);
      step();
    end
    idle_inputs();
    vblank_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("final_level", 32'(level_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_wr_queue.md
DISP_WR_QUEUE -- requirements
Module: disp_wr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low (decided: one clock, async active-low reset).
REQ-004 SHALL have port wr_en_i, input, 1 bit: producer write strobe, one entry per high cycle.
REQ-005 SHALL have port wr_addr_i, input, disp_addr_t: display-memory cell address.
REQ-006 SHALL have port wr_data_i, input, disp_data_t (16 bits: back color[15:12], fore color[11:8], char[7:0]): cell data.
REQ-007 SHALL have port vblank_i, input, 1 bit: vertical-blank drain window.
REQ-008 SHALL have port flush_i, input, 1 bit: single-cycle pulse requesting a drain regardless of blanking.
REQ-009 SHALL have port ram_busy_i, input, 1 bit: scanout owns the display-RAM port this cycle.
REQ-010 SHALL have port clear_ovf_i, input, 1 bit: clears the overflow flag.
REQ-011 SHALL have ports ram_wr_en_o (output, 1 bit), ram_wr_addr_o (output, disp_addr_t) and ram_wr_data_o (output, disp_data_t): registered display-RAM write port.
REQ-012 SHALL have port full_o, output, 1 bit: the queue holds DEPTH entries.
REQ-013 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current entry count.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a write was dropped.

Function
REQ-015 SHALL store entries FIFO-ordered; address and data SHALL be emitted exactly as received, in order.
REQ-016 SHALL accept a push when wr_en_i=1 and either level<DEPTH or a pop occurs in the same cycle.
REQ-017 SHALL drop a push when wr_en_i=1, level=DEPTH and no pop occurs that cycle; on a drop it SHALL set overflow_o on the next edge, and queue contents SHALL be unchanged.
REQ-018 SHALL hold overflow_o until clear_ovf_i=1; clear_ovf_i SHALL win over a same-cycle set.
REQ-019 SHALL implement FSM states Q_IDLE, Q_DRAIN and Q_FLUSH.
REQ-020 SHALL transition Q_IDLE->Q_FLUSH on flush_i=1 (priority); otherwise Q_IDLE->Q_DRAIN on vblank_i=1 with level>0.
REQ-021 SHALL transition Q_DRAIN->Q_IDLE when vblank_i=0 or level=0; Q_DRAIN->Q_FLUSH on flush_i=1.
REQ-022 SHALL transition Q_FLUSH->Q_IDLE only when level=0; vblank_i SHALL be ignored in Q_FLUSH, and a flush_i pulse received in Q_FLUSH SHALL have no additional effect.
REQ-023 SHALL pop one entry per cycle when state is Q_DRAIN or Q_FLUSH, level>0 and ram_busy_i=0; no pop SHALL occur while ram_busy_i=1.
REQ-024 SHALL drive ram_wr_en_o=1 with the popped address and data on the edge following the pop decision (1-cycle latency), and ram_wr_en_o=0 otherwise.
REQ-025 SHALL leave ram_wr_addr_o and ram_wr_data_o holding their last values when ram_wr_en_o=0.
REQ-026 SHALL update level_o each cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop; full_o SHALL equal (level_o==DEPTH).
REQ-027 SHALL make a push into an empty queue poppable no earlier than the following cycle (no same-cycle bypass).
REQ-028 SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-029 SHALL, while rst_ni=0, force state=Q_IDLE, pointers=0, level_o=0, full_o=0, overflow_o=0, ram_wr_en_o=0, ram_wr_addr_o=0 and ram_wr_data_o=0.
REQ-030 SHALL discard all queued entries on reset mid-drain, with no RAM write issued after rst_ni falls.
REQ-031 SHALL not require storage-array contents to be reset.

Structure
REQ-032 SHALL take disp_addr_t, disp_data_t and color_t from video_package; a wr_queue_st enum (2-bit) SHALL be added to that package.
REQ-033 SHALL contain one sub-module, disp_wr_fifo (storage, pointers, level), with the FSM and RAM port in disp_wr_queue.

Verification
REQ-034 SHALL cover: 3 pushes (addr 0,1,2; data 16'h0148,16'h0265,16'h036C), vblank_i=1, ram_busy_i=0 -> 3 consecutive ram_wr_en_o pulses in the same order, each starting 1 cycle after its pop, then level_o=0 and state Q_IDLE.
REQ-035 SHALL cover: 9 pushes with DEPTH=8 and no drain -> full_o=1 after the 8th, 9th dropped, overflow_o=1; clear_ovf_i pulse -> overflow_o=0.
REQ-036 SHALL cover: draining 4 entries with ram_busy_i high on alternate cycles -> writes only in cycles following ram_busy_i=0, with no loss and no duplication.
REQ-037 SHALL cover: vblank_i falls with 2 entries left -> state Q_IDLE and level_o=2; flush_i pulse with vblank_i=0 -> both entries written, then Q_IDLE.
REQ-038 SHALL cover: level=8 with push and pop in the same cycle -> push accepted, level_o stays 8, overflow_o stays 0.
REQ-039 SHALL cover: rst_ni asserted mid-drain at level 5 -> ram_wr_en_o=0 immediately, and level_o=0 after release.
